mult_rr_arbiter: RTL and testbench
==================================

Name: mult_rr_arbiter

Overview:
- Shares one pipelined unsigned multiplier between NUM_REQ requesters with round-robin arbitration.
- Each requester has a valid/ready operand channel and a valid/ready result channel.
- Each result carries the product and is routed back to the requester that issued the operation.
- Sits between the AXI4-Lite register front ends and the single shared multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand width in bits.
- MULT_LAT, 3, multiplier pipeline depth in cycles (1..8).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester operand accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  flattened operand A; requester i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  flattened operand B; same layout as req_a.
- rsp_valid  out  NUM_REQ  one-hot result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  2*DATA_W  product; meaningful only when any rsp_valid bit is set.
- busy  out  1  high while any operation is in flight or an output is pending.

Behaviour:
- Reset: all outputs 0, pipeline valids cleared, rr pointer = 0. Reset mid-operation discards all in-flight results; none are delivered afterwards.
- Arbitration:
  - Each cycle the arbiter scans req_valid starting at index ptr, wrapping mod NUM_REQ.
  - The first set bit wins; req_ready[win] = 1 only if the pipeline is not stalled.
  - req_ready is combinational from req_valid, ptr and the stall signal.
  - A transfer occurs when req_valid[i] && req_ready[i].
  - On a transfer, ptr <= win+1, wrapping to 0 after NUM_REQ-1. With no transfer, ptr holds.
- Pipeline:
  - Stage 0 captures a, b and the requester tag (clog2(NUM_REQ) bits).
  - The product appears in stage MULT_LAT.
  - Latency from accept to rsp_valid is exactly MULT_LAT cycles when there is no stall.
- Output:
  - The final stage drives rsp_valid[tag] and rsp_data = a*b, full 2*DATA_W width, unsigned, never truncated.
  - rsp_valid and rsp_data hold stable until rsp_ready[tag] is seen.
- Stall:
  - stall = final stage valid && !rsp_ready[tag].
  - While stalled the whole pipeline freezes and all req_ready are 0.
  - Bubbles are not compressed.
- Simultaneous events: a new accept and a result handshake in the same cycle are both legal and produce full throughput, 1 op/cycle.
- Requester rules:
  - A requester must hold req_a, req_b and req_valid until accepted.
  - A requester may have multiple operations in flight; results return in issue order.
- busy = OR of all stage valids.

Optional Feature:
- Macro MULT_RR_ARBITER_STATS_EN adds outputs stat_ops (32 bits) and stat_stall (32 bits).
  - stat_ops counts accepted operations.
  - stat_stall counts stalled cycles.
  - Both counters reset to 0, wrap at 2^32, and count with no saturation.
- Without the macro, these ports and their counters do not exist.

Decomposition:
- Package mult_arb_pkg holds:
  - the TAG_W function/constant clog2(NUM_REQ);
  - the stage record typedef {valid, tag, a, b / product};
  - localparam PTR_RESET = 0.
- Sub-module mult_pipe: a MULT_LAT-deep multiplier with an enable (stall) input, carrying valid and tag alongside the product.
- Arbitration and response routing stay in the top.

Test Plan:
- Single request: requester 2 sends a=0x0003, b=0x0005 at cycle t with rsp_ready all 1 -> rsp_valid=4'b0100, rsp_data=0x0000000F at t+3; busy 0 at t+4.
- All four requesters valid continuously -> grants 0,1,2,3,0 in consecutive cycles; one result per cycle after the initial 3-cycle latency.
- Max values: a=b=0xFFFF -> rsp_data=0xFFFE0001.
- Backpressure: rsp_ready[1]=0 for 5 cycles with requester 1's result at the head -> rsp_valid and rsp_data stable, all req_ready=0 for 5 cycles; no result is lost or duplicated after release.
- Reset mid-flight: assert ARESET for 1 cycle with 3 ops in flight -> rsp_valid stays 0 afterwards; next grant goes to requester 0.
- With MULT_RR_ARBITER_STATS_EN: 10 ops and 5 stall cycles -> stat_ops=10, stat_stall=5; both read 0 after reset.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
// The stage record below describes the default configuration.
package mult_arb_pkg;

    localparam int NUM_REQ_DEF  = 4;
    localparam int DATA_W_DEF   = 16;
    localparam int MULT_LAT_DEF = 3;
    localparam int PTR_RESET    = 0;

    function automatic int tag_w(input int num_req);
        if (num_req > 1) begin
            return $clog2(num_req);
        end else begin
            return 1;
        end
    endfunction

    localparam int TAG_W_DEF = tag_w(NUM_REQ_DEF);

    // data holds {a, b} in stage 0 and the product in every later stage
    typedef struct packed {
        logic                    valid;
        logic [TAG_W_DEF-1:0]    tag;
        logic [2*DATA_W_DEF-1:0] data;
    } stage_t;

endpackage

// File: rtl/mult_pipe.sv
// MULT_LAT-deep unsigned multiplier pipeline carrying valid and requester tag.
// The whole pipeline advances only while en is high.
module mult_pipe #(
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 2,
    parameter int MULT_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                op_valid,
    input  logic [TAG_W-1:0]    op_tag,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic                res_valid,
    output logic [TAG_W-1:0]    res_tag,
    output logic [2*DATA_W-1:0] res_data,
    output logic                any_valid
);

    localparam int PROD_W = 2 * DATA_W;

    // same layout as mult_arb_pkg::stage_t, sized from this instance
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [PROD_W-1:0] data;
    } stage_rec_t;

    stage_rec_t stage_r [MULT_LAT];
    stage_rec_t entry_s;

    function automatic logic [PROD_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    // Entry record: raw operands, or the product when there is only one stage
    always_comb begin
        entry_s.valid = op_valid;
        entry_s.tag   = op_tag;
        if (MULT_LAT == 1) begin
            entry_s.data = mul_full(op_a, op_b);
        end else begin
            entry_s.data = {op_a, op_b};
        end
    end

    // Stage registers; the multiply sits between stage 0 and stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                stage_r[i] <= '0;
            end
        end else if (en) begin
            stage_r[0] <= entry_s;
            for (int i = 1; i < MULT_LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
                if (i == 1) begin
                    stage_r[i].data <= mul_full(stage_r[0].data[PROD_W-1:DATA_W],
                                                stage_r[0].data[DATA_W-1:0]);
                end
            end
        end
    end

    // Occupancy of any stage
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < MULT_LAT; i++) begin
            any_valid = any_valid | stage_r[i].valid;
        end
    end

    assign res_valid = stage_r[MULT_LAT-1].valid;
    assign res_tag   = stage_r[MULT_LAT-1].tag;
    assign res_data  = stage_r[MULT_LAT-1].data;

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin sharing of one pipelined multiplier between NUM_REQ requesters.
// Define MULT_RR_ARBITER_STATS_EN to add the stat_ops / stat_stall counters.
module mult_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [2*DATA_W-1:0]       rsp_data,
    output logic                      busy
`ifdef MULT_RR_ARBITER_STATS_EN
    ,
    output logic [31:0]               stat_ops,
    output logic [31:0]               stat_stall
`endif
);

    localparam int TAG_W = tag_w(NUM_REQ);
    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);

    logic [TAG_W-1:0]    ptr_r;
    logic [TAG_W-1:0]    win_s;
    logic [TAG_W-1:0]    cand_s;
    logic                found_s;
    logic                grant_s;
    logic                stall_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic                res_valid_s;
    logic [TAG_W-1:0]    res_tag_s;
    logic [2*DATA_W-1:0] res_data_s;
    logic                any_valid_s;

    // Rotating-priority scan starting at ptr_r
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(ptr_r) + k >= NUM_REQ) begin
                cand_s = TAG_W'(int'(ptr_r) + k - NUM_REQ);
            end else begin
                cand_s = TAG_W'(int'(ptr_r) + k);
            end
            if (!found_s && req_valid[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
                win_s   = win_s;
            end
        end
    end

    // A result waiting on its own requester freezes everything behind it
    assign stall_s = res_valid_s & ~rsp_ready[res_tag_s];
    assign grant_s = found_s & ~stall_s & ~ARESET;

    // One-hot operand accept
    always_comb begin
        req_ready = '0;
        if (grant_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Operand select for the winning requester
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (TAG_W'(i) == win_s) begin
                sel_a_s = req_a[i*DATA_W +: DATA_W];
                sel_b_s = req_b[i*DATA_W +: DATA_W];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // Pointer moves just past the winner on every transfer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ptr_r <= TAG_W'(PTR_RESET);
        end else if (grant_s) begin
            ptr_r <= (win_s == LAST_IDX) ? TAG_W'(PTR_RESET) : win_s + TAG_W'(1'b1);
        end
    end

    mult_pipe #(
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .MULT_LAT (MULT_LAT)
    ) u_pipe (
        .clk       (ACLK),
        .rst       (ARESET),
        .en        (~stall_s),
        .op_valid  (grant_s),
        .op_tag    (win_s),
        .op_a      (sel_a_s),
        .op_b      (sel_b_s),
        .res_valid (res_valid_s),
        .res_tag   (res_tag_s),
        .res_data  (res_data_s),
        .any_valid (any_valid_s)
    );

    // Route the final stage back to the issuing requester
    always_comb begin
        rsp_valid = '0;
        if (res_valid_s) begin
            rsp_valid[res_tag_s] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

    assign rsp_data = res_data_s;
    assign busy     = any_valid_s;

`ifdef MULT_RR_ARBITER_STATS_EN
    // Free-running accept and stall counters
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stat_ops   <= 32'd0;
            stat_stall <= 32'd0;
        end else begin
            if (grant_s) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if (stall_s) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Scoreboard bench for mult_rr_arbiter (4 requesters, 16-bit operands, 3-cycle latency).
module tb_mult_rr_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 16;
    localparam int MULT_LAT = 3;

    logic        tb_ACLK = 1'b0;
    logic        tb_ARESET;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
`ifdef MULT_RR_ARBITER_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_stall;
`endif

    typedef struct {
        int          tag;
        logic [31:0] prod;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 tb_ACLK = ~tb_ACLK;

    mult_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .ACLK      (tb_ACLK),
        .ARESET    (tb_ARESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef MULT_RR_ARBITER_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    // Scoreboard: push on every accept, pop/compare on every result handshake
    initial begin
        int   t;
        exp_t e;
        forever begin
            @(negedge tb_ACLK);
            if (tb_ARESET === 1'b1) begin
                exp_q.delete();
            end else begin
                if (rsp_valid !== 4'b0000) begin
                    n_checks++;
                    if (!$onehot(rsp_valid)) begin
                        n_fail++;
                        $display("FAIL rsp_onehot: rsp_valid=%b required one-hot", rsp_valid);
                    end else begin
                        t = 0;
                        for (int i = 0; i < NUM_REQ; i++) if (rsp_valid[i]) t = i;
                        if (rsp_ready[t]) begin
                            n_checks++;
                            if (exp_q.size() == 0) begin
                                n_fail++;
                                $display("FAIL rsp_unexpected: got tag %0d data %h, required no result", t, rsp_data);
                            end else begin
                                e = exp_q.pop_front();
                                if (e.tag != t || rsp_data !== e.prod) begin
                                    n_fail++;
                                    $display("FAIL rsp_scoreboard: got tag %0d data %h, required tag %0d data %h",
                                             t, rsp_data, e.tag, e.prod);
                                end
                            end
                        end
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        exp_q.push_back('{tag: i,
                                          prod: 32'(req_a[i*16 +: 16]) * 32'(req_b[i*16 +: 16])});
                    end
                end
            end
        end
    end

    task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic apply_reset();
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b1;
        req_valid = 4'b0000;
        @(posedge tb_ACLK); #1;
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 60 && (busy !== 1'b0 || exp_q.size() != 0); c++) @(negedge tb_ACLK);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%b pending=%0d, required busy=0 pending=0", name, busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        @(posedge tb_ACLK);
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
        n_checks++;
        if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0000", rsp_valid); end
        n_checks++;
        if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
`ifdef MULT_RR_ARBITER_STATS_EN
        n_checks++;
        if (stat_ops !== 32'd0 || stat_stall !== 32'd0) begin
            n_fail++; $display("FAIL reset_stats: got ops %0d stall %0d required 0 0", stat_ops, stat_stall);
        end
`endif
        req_valid = 4'b0000;
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
    endtask

    task automatic single_op(input string name, input int lane, input logic [15:0] a,
                             input logic [15:0] b, input logic [31:0] prod);
        logic [3:0] lane_bit;
        lane_bit = 4'(1 << lane);
        @(posedge tb_ACLK); #1;
        set_lane(lane, a, b);
        req_valid = lane_bit;
        rsp_ready = 4'b1111;
        @(negedge tb_ACLK);
        n_checks++;
        if (req_ready !== lane_bit) begin n_fail++; $display("FAIL %s_grant: got %b required %b", name, req_ready, lane_bit); end
        @(posedge tb_ACLK); #1;
        req_valid = 4'b0000;
        for (int c = 1; c <= MULT_LAT; c++) begin
            @(negedge tb_ACLK);
            if (c < MULT_LAT) begin
                n_checks++;
                if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL %s_early: cycle %0d rsp_valid=%b busy=%b required 0000 1", name, c, rsp_valid, busy);
                end
            end else begin
                n_checks++;
                if (rsp_valid !== lane_bit || rsp_data !== prod) begin
                    n_fail++; $display("FAIL %s_result: got %b %h required %b %h", name, rsp_valid, rsp_data, lane_bit, prod);
                end
            end
        end
        @(negedge tb_ACLK);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after: got %b required 0", name, busy); end
        drain(name);
    endtask

    task automatic test_single();
        single_op("single", 2, 16'h0003, 16'h0005, 32'h0000000F);
    endtask

    task automatic test_max();
        single_op("max", 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    endtask

    task automatic test_round_robin();
        apply_reset();
        rsp_ready = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 16'(i * 273 + 1), 16'(240 - i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge tb_ACLK);
            n_checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                n_fail++; $display("FAIL rr_grant: step %0d got %b required %b", k, req_ready, 4'(1 << (k % 4)));
            end
            if (k >= MULT_LAT) begin
                n_checks++;
                if (rsp_valid !== 4'(1 << ((k - MULT_LAT) % 4))) begin
                    n_fail++; $display("FAIL rr_throughput: step %0d got %b required %b", k, rsp_valid,
                                       4'(1 << ((k - MULT_LAT) % 4)));
                end
            end
            @(posedge tb_ACLK); #1;
            if (k == 7) req_valid = 4'b0000;
            else set_lane(k % 4, 16'(k * 1000 + 7), 16'(k * 333 + 11));
        end
        drain("rr");
    endtask

    task automatic test_backpressure();
        apply_reset();
        rsp_ready = 4'b1101;
        set_lane(1, 16'h0007, 16'h0009);
        req_valid = 4'b0010;
        @(negedge tb_ACLK);
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b required 0010", req_ready); end
        @(posedge tb_ACLK); #1;
        req_valid = 4'b0000;
        fork
            begin : drv0
                int n;
                n = 0;
                set_lane(0, 16'h0100, 16'h0002);
                req_valid[0] = 1'b1;
                for (int c = 0; c < 60 && n < 9; c++) begin
                    @(negedge tb_ACLK);
                    if (req_ready[0]) begin
                        n++;
                        @(posedge tb_ACLK); #1;
                        if (n == 9) req_valid[0] = 1'b0;
                        else set_lane(0, 16'(16'h0100 + n), 16'(n + 2));
                    end
                end
                req_valid[0] = 1'b0;
                n_checks++;
                if (n != 9) begin n_fail++; $display("FAIL bp_req0_accepts: got %0d required 9", n); end
            end
            begin : hold1
                int found;
                found = 0;
                for (int c = 0; c < 20 && found == 0; c++) begin
                    @(negedge tb_ACLK);
                    if (rsp_valid === 4'b0010) found = 1;
                end
                n_checks++;
                if (found == 0) begin n_fail++; $display("FAIL bp_head_timeout: got no result, required rsp_valid 0010"); end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge tb_ACLK);
                    n_checks++;
                    if (rsp_valid !== 4'b0010 || rsp_data !== 32'd63) begin
                        n_fail++; $display("FAIL bp_hold: cycle %0d got %b %h required 0010 0000003f", k, rsp_valid, rsp_data);
                    end
                    n_checks++;
                    if (req_ready !== 4'b0000) begin
                        n_fail++; $display("FAIL bp_req_ready: cycle %0d got %b required 0000", k, req_ready);
                    end
                end
                @(posedge tb_ACLK); #1;
                rsp_ready = 4'b1111;
            end
        join
        drain("bp");
`ifdef MULT_RR_ARBITER_STATS_EN
        n_checks++;
        if (stat_ops !== 32'd10) begin n_fail++; $display("FAIL stat_ops: got %0d required 10", stat_ops); end
        n_checks++;
        if (stat_stall !== 32'd5) begin n_fail++; $display("FAIL stat_stall: got %0d required 5", stat_stall); end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rsp_ready = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 16'(i + 20), 16'(i + 30));
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge tb_ACLK);
            n_checks++;
            if (req_ready !== 4'(1 << k)) begin
                n_fail++; $display("FAIL mid_grant: step %0d got %b required %b", k, req_ready, 4'(1 << k));
            end
        end
        @(posedge tb_ACLK); #1;
        req_valid = 4'b0000;
        tb_ARESET = 1'b1;
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge tb_ACLK);
            n_checks++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_discard: cycle %0d rsp_valid=%b busy=%b required 0000 0", c, rsp_valid, busy);
            end
        end
`ifdef MULT_RR_ARBITER_STATS_EN
        n_checks++;
        if (stat_ops !== 32'd0 || stat_stall !== 32'd0) begin
            n_fail++; $display("FAIL mid_stats: got ops %0d stall %0d required 0 0", stat_ops, stat_stall);
        end
`endif
        @(posedge tb_ACLK); #1;
        req_valid = 4'b1111;
        @(negedge tb_ACLK);
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_next_grant: got %b required 0001", req_ready); end
        @(posedge tb_ACLK); #1;
        req_valid = 4'b0000;
        drain("mid");
    endtask

    initial begin
        tb_ARESET = 1'b1;
        req_valid = 4'b0000;
        req_a     = 64'h0;
        req_b     = 64'h0;
        rsp_ready = 4'b1111;
        test_reset();
        test_single();
        test_max();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
